// File: rtl/tt_bist_pkg.sv
// Shared types and LFSR helpers for the BIST harness: FSM state enum,
// maximal-length tap table (widths 4..16) and one Fibonacci step.
package tt_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [15:0] taps(input int unsigned w);
    case (w)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      default: taps = 16'hD008;
    endcase
  endfunction

  // Shift left, feed back the XOR of tapped bits; result masked to w bits.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input int unsigned w);
    logic [15:0] mask;
    mask      = 16'((17'd1 << w) - 17'd1);
    lfsr_step = ((cur << 1) | {15'd0, ^(cur & taps(w))}) & mask;
  endfunction

endpackage

// File: rtl/tt_bist_lfsr.sv
// Stimulus LFSR: load_i takes seed_i (0 replaced by 1), advance_i steps once.
// value_o is the registered LFSR state; no backpressure.
module tt_bist_lfsr
  import tt_bist_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
    end else if (advance_i) begin
      lfsr_d = WIDTH'(lfsr_step(16'(lfsr_q), WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/tt_bist_harness.sv
// BIST harness: LFSR stimulus, one vector/cycle, MISR compaction LATENCY cycles later.
// Optional golden comparator under BIST_GOLDEN_CMP_EN; no backpressure, abort wins over start.
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_VECTORS = 256,
  parameter int               LATENCY     = 0,
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] stim_out,
  output logic             stim_valid,
  input  logic [WIDTH-1:0] resp_in,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic             pass
);

  localparam int            CW       = $clog2(NUM_VECTORS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_VECTORS - 1);
  localparam logic [2:0]    DRN_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       drn_q, drn_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] lfsr_val;
  logic             accept, dvalid;

  assign accept = start && !abort && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = (LATENCY > 0) ? S_DRAIN : S_DONE;
          drn_d   = '0;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 3'd1;
        if (drn_q == DRN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // MISR only compacts while a run is live; an abort freezes it.
  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = '0;
    end else if (dvalid && !abort && (state_q == S_RUN || state_q == S_DRAIN)) begin
      sig_d = WIDTH'(lfsr_step(16'(sig_q), WIDTH)) ^ resp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      sig_q   <= sig_d;
    end
  end

  generate
    if (LATENCY == 0) begin : g_nodly
      assign dvalid = stim_valid;
    end else begin : g_dly
      logic [LATENCY-1:0] dv_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        dv_q <= '0;
        else if (abort) dv_q <= '0;
        else            dv_q <= LATENCY'({dv_q, stim_valid});
      end
      assign dvalid = dv_q[LATENCY-1];
    end
  endgenerate

  tt_bist_lfsr #(.WIDTH(WIDTH)) u_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .advance_i (state_q == S_RUN),
    .seed_i    (SEED),
    .value_o   (lfsr_val)
  );

  assign stim_valid = (state_q == S_RUN);
  assign stim_out   = stim_valid ? lfsr_val : '0;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign signature  = sig_q;

`ifdef BIST_GOLDEN_CMP_EN
  assign pass = done && (sig_q == golden);
`else
  logic unused_golden;
  assign unused_golden = ^golden;
  assign pass          = 1'b0;
`endif

endmodule
